// File: rtl/gpio_pkg.sv
// Shared constants and types for the Wishbone GPIO slave.
// Register offsets (byte addresses inside the 4 KiB window), register index
// enum decoded from adr[4:2], and a byte-lane to bit-mask helper.
package gpio_pkg;

  localparam int unsigned GPIO_WINDOW = 32'h1000;
  localparam int unsigned GPIO_OFS_W  = $clog2(GPIO_WINDOW);
  localparam int unsigned GPIO_DW     = 32;

  localparam logic [GPIO_OFS_W-1:0] GPIO_DATA_OUT = 12'h000;
  localparam logic [GPIO_OFS_W-1:0] GPIO_DIR      = 12'h004;
  localparam logic [GPIO_OFS_W-1:0] GPIO_DATA_IN  = 12'h008;
  localparam logic [GPIO_OFS_W-1:0] GPIO_OUT_SET  = 12'h00C;
  localparam logic [GPIO_OFS_W-1:0] GPIO_OUT_CLR  = 12'h010;
  localparam logic [GPIO_OFS_W-1:0] GPIO_RISE_EN  = 12'h014;
  localparam logic [GPIO_OFS_W-1:0] GPIO_FALL_EN  = 12'h018;
  localparam logic [GPIO_OFS_W-1:0] GPIO_IRQ_PEND = 12'h01C;

  typedef enum logic [2:0] {
    REG_DATA_OUT = 3'd0,
    REG_DIR      = 3'd1,
    REG_DATA_IN  = 3'd2,
    REG_OUT_SET  = 3'd3,
    REG_OUT_CLR  = 3'd4,
    REG_RISE_EN  = 3'd5,
    REG_FALL_EN  = 3'd6,
    REG_IRQ_PEND = 3'd7
  } reg_idx_e;

  // Expand the 4 byte-lane selects into a 32-bit write mask.
  function automatic logic [GPIO_DW-1:0] sel_to_mask(input logic [GPIO_DW/8-1:0] sel);
    logic [GPIO_DW-1:0] mask;
    mask = '0;
    for (int b = 0; b < GPIO_DW / 8; b++) begin
      mask[8*b +: 8] = {8{sel[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone pipelined bus bundle.
// adr/dat_m/sel/we/cyc/stb driven by the master; dat_s/ack/stall/err by the slave.
interface wb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_m;
  logic [DW-1:0]   dat_s;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic            ack;
  logic            stall;
  logic            err;

  modport slave  (input adr, dat_m, sel, we, cyc, stb, output dat_s, ack, stall, err);
  modport master (output adr, dat_m, sel, we, cyc, stb, input dat_s, ack, stall, err);
endinterface

// File: rtl/gpio_debounce.sv
// Single-pin debounce filter, only instantiated when GPIO_DEBOUNCE_EN is defined.
// Ports: clk, rst_n (async active-low), d (synchronised input), q (filtered level).
// q takes the value of d once d has stayed unchanged long enough for the
// stability counter to reach DEB_CYCLES-1; any change restarts the count.
module gpio_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  localparam int unsigned          CNT_W   = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_HIT = CNT_W'(DEB_CYCLES - 1);

  logic             cand;
  logic [CNT_W-1:0] cnt;

  // Candidate tracking with saturating stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= 1'b0;
      cnt  <= '0;
      q    <= 1'b0;
    end else if (d != cand) begin
      cand <= d;
      cnt  <= '0;
    end else begin
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_HIT) q <= cand;
    end
  end

endmodule

// File: rtl/wb_gpio.sv
// Parametrised Wishbone GPIO slave.
// Ports: clk, rst_n (async active-low), wb (wb_if slave), gpio_i (raw pads),
//        gpio_o (DATA_OUT), gpio_oe (DIR), irq (OR of IRQ_PENDING, registered).
// Optional input debounce enabled by defining GPIO_DEBOUNCE_EN.
module wb_gpio
  import gpio_pkg::*;
#(
  parameter int unsigned   N          = 8,
  parameter int unsigned   DEB_CYCLES = 16,
  parameter logic [N-1:0]  DIR_RST    = '0,
  parameter logic [N-1:0]  OUT_RST    = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_if.slave          wb,
  input  logic [N-1:0] gpio_i,
  output logic [N-1:0] gpio_o,
  output logic [N-1:0] gpio_oe,
  output logic         irq
);

  logic [N-1:0] data_out, dir, rise_en, fall_en, irq_pend;
  logic [N-1:0] sync_s1, sync_s2, data_in, data_in_prev;

  // Bus decode
  logic                  req_c, wr_c, mapped_c;
  logic [GPIO_OFS_W-1:0] ofs_c;
  reg_idx_e              idx_c;
  logic [N-1:0]          be_c, wr_bits_c, w1c_c, rise_c, fall_c;
  logic [GPIO_DW-1:0]    rdata_c;
  logic                  unused_adr;

  assign req_c     = wb.cyc & wb.stb;
  assign ofs_c     = wb.adr[GPIO_OFS_W-1:0];
  assign mapped_c  = ({ofs_c[GPIO_OFS_W-1:2], 2'b00} <= GPIO_IRQ_PEND);
  assign idx_c     = reg_idx_e'(ofs_c[4:2]);
  assign be_c      = N'(sel_to_mask(wb.sel));
  assign wr_bits_c = N'(wb.dat_m) & be_c;
  assign wr_c      = req_c & wb.we & mapped_c;
  assign unused_adr = ^{wb.adr[$bits(wb.adr)-1:GPIO_OFS_W], wb.adr[1:0]};

  assign wb.stall = 1'b0;
  assign wb.err   = 1'b0;
  assign gpio_o   = data_out;
  assign gpio_oe  = dir;

  // Writable registers; OUT_SET/OUT_CLR act on DATA_OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= OUT_RST;
      dir      <= DIR_RST;
      rise_en  <= '0;
      fall_en  <= '0;
    end else if (wr_c) begin
      case (idx_c)
        REG_DATA_OUT: data_out <= (data_out & ~be_c) | wr_bits_c;
        REG_DIR:      dir      <= (dir & ~be_c) | wr_bits_c;
        REG_OUT_SET:  data_out <= data_out | wr_bits_c;
        REG_OUT_CLR:  data_out <= data_out & ~wr_bits_c;
        REG_RISE_EN:  rise_en  <= (rise_en & ~be_c) | wr_bits_c;
        REG_FALL_EN:  fall_en  <= (fall_en & ~be_c) | wr_bits_c;
        default:      ;
      endcase
    end
  end

  // Read mux; write-only and unmapped locations return 0.
  always_comb begin
    rdata_c = '0;
    if (mapped_c) begin
      case (idx_c)
        REG_DATA_OUT: rdata_c = GPIO_DW'(data_out);
        REG_DIR:      rdata_c = GPIO_DW'(dir);
        REG_DATA_IN:  rdata_c = GPIO_DW'(data_in);
        REG_RISE_EN:  rdata_c = GPIO_DW'(rise_en);
        REG_FALL_EN:  rdata_c = GPIO_DW'(fall_en);
        REG_IRQ_PEND: rdata_c = GPIO_DW'(irq_pend);
        default:      rdata_c = '0;
      endcase
    end
  end

  // Single-cycle ack with registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.ack   <= 1'b0;
      wb.dat_s <= '0;
    end else begin
      wb.ack   <= req_c;
      wb.dat_s <= req_c ? rdata_c : '0;
    end
  end

  // Two-flop synchroniser for asynchronous pad inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= gpio_i;
      sync_s2 <= sync_s1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  // Debounced inputs: each filter's registered output is the DATA_IN bit.
  for (genvar i = 0; i < N; i++) begin : g_deb
    gpio_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sync_s2[i]),
      .q     (data_in[i])
    );
  end
`else
  // No filter: DATA_IN is one register after the synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_in <= '0;
    else        data_in <= sync_s2;
  end
`endif

  // Edge detect; a new edge beats a same-cycle W1C.
  assign rise_c = ~data_in_prev &  data_in & rise_en;
  assign fall_c =  data_in_prev & ~data_in & fall_en;
  assign w1c_c  = (wr_c && idx_c == REG_IRQ_PEND) ? wr_bits_c : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_in_prev <= '0;
      irq_pend     <= '0;
      irq          <= 1'b0;
    end else begin
      data_in_prev <= data_in;
      irq_pend     <= (irq_pend & ~w1c_c) | rise_c | fall_c;
      irq          <= |irq_pend;
    end
  end

endmodule
